// File: rtl/gb_clk_gen_if.sv
// Control and enable bundle between the clock/reset sequencer and the Game Boy core.
// The slave side is the sequencer; the master side supplies PLL lock and mode requests.
interface gb_clk_gen_if;
  logic pll_locked;
  logic fast_fwd;
  logic pause_req;
  logic core_reset;
  logic ce;
  logic ce_n;
  logic ce_2x;
  logic paused;

  modport master (
    output pll_locked,
    output fast_fwd,
    output pause_req,
    input  core_reset,
    input  ce,
    input  ce_n,
    input  ce_2x,
    input  paused
  );

  modport slave (
    input  pll_locked,
    input  fast_fwd,
    input  pause_req,
    output core_reset,
    output ce,
    output ce_n,
    output ce_2x,
    output paused
  );
endinterface

// File: rtl/gb_clk_gen.sv
// Clock-enable and reset sequencer behind the system PLL: holds the core in reset until lock
// has been stable, then emits frame-aligned ce / ce_n / ce_2x with fast-forward and pause.
module gb_clk_gen #(
  parameter int unsigned RESET_HOLD = 256
) (
  input logic         clk_sys,
  input logic         rst_n,
  gb_clk_gen_if.slave bus
);

  typedef enum logic [1:0] {StWaitLock, StHold, StRun, StPaused} state_e;

  localparam logic [15:0] HoldLast = 16'(RESET_HOLD - 1);

  state_e      state_q, state_d;
  logic [2:0]  div_q, div_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        ff_mode_q, ff_mode_d;
  logic        sync1_q, locked_s;
  logic        run_d, ce_d, ce_n_d, ce_2x_d;
  logic        core_reset_q, ce_q, ce_n_q, ce_2x_q, paused_q;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    hold_cnt_d = hold_cnt_q;
    ff_mode_d  = ff_mode_q;
    unique case (state_q)
      StWaitLock: begin
        hold_cnt_d = '0;
        div_d      = '0;
        if (locked_s) state_d = StHold;
      end
      StHold: begin
        div_d = '0;
        if (!locked_s) begin
          state_d    = StWaitLock;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d    = StRun;
          hold_cnt_d = '0;
          ff_mode_d  = bus.fast_fwd;
        end else begin
          hold_cnt_d = 16'(hold_cnt_q + 16'd1);
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          div_d   = '0;
        end else begin
          div_d = 3'(div_q + 3'd1);
          // Frame boundary: the only point where rate and pause may change.
          if (div_q == 3'd7) begin
            ff_mode_d = bus.fast_fwd;
            if (bus.pause_req) state_d = StPaused;
          end
        end
      end
      StPaused: begin
        div_d = '0;
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (!bus.pause_req) begin
          state_d   = StRun;
          ff_mode_d = bus.fast_fwd;
        end
      end
      default: begin
        state_d = StWaitLock;
        div_d   = '0;
      end
    endcase
  end

  // Enables are decoded from the next-state phase so the registered pulses line up with div_q.
  always_comb begin
    run_d = (state_d == StRun);
    if (ff_mode_d) begin
      ce_d    = run_d && (div_d[1:0] == 2'd0);
      ce_n_d  = run_d && (div_d[1:0] == 2'd2);
      ce_2x_d = run_d && !div_d[0];
    end else begin
      ce_d    = run_d && (div_d == 3'd0);
      ce_n_d  = run_d && (div_d == 3'd4);
      ce_2x_d = run_d && (div_d[1:0] == 2'd0);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      locked_s     <= 1'b0;
      state_q      <= StWaitLock;
      div_q        <= '0;
      hold_cnt_q   <= '0;
      ff_mode_q    <= 1'b0;
      core_reset_q <= 1'b1;
      ce_q         <= 1'b0;
      ce_n_q       <= 1'b0;
      ce_2x_q      <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      sync1_q      <= bus.pll_locked;
      locked_s     <= sync1_q;
      state_q      <= state_d;
      div_q        <= div_d;
      hold_cnt_q   <= hold_cnt_d;
      ff_mode_q    <= ff_mode_d;
      core_reset_q <= !((state_d == StRun) || (state_d == StPaused));
      ce_q         <= ce_d;
      ce_n_q       <= ce_n_d;
      ce_2x_q      <= ce_2x_d;
      paused_q     <= (state_d == StPaused);
    end
  end

  assign bus.core_reset = core_reset_q;
  assign bus.ce         = ce_q;
  assign bus.ce_n       = ce_n_q;
  assign bus.ce_2x      = ce_2x_q;
  assign bus.paused     = paused_q;

endmodule

// File: tb/tb_gb_clk_gen.sv
// Directed bench for gb_clk_gen: stimulus queues per-cycle expected outputs, a negedge monitor
// pops and compares them against {core_reset, ce, ce_n, ce_2x, paused}.
module tb_gb_clk_gen;

  typedef struct {
    int         cyc;
    logic [4:0] v;
    string      tag;
  } exp_t;

  localparam logic [4:0] VRst   = 5'b10000;
  localparam logic [4:0] VPause = 5'b00001;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  gb_clk_gen_if bus ();

  gb_clk_gen #(.RESET_HOLD(16)) dut (
    .clk_sys(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_vec(input int c0, input int c1, input logic [4:0] v, input string tag);
    for (int c = c0; c <= c1; c++) exp_q.push_back('{cyc: c, v: v, tag: tag});
  endtask

  // Expected enables for a run whose frames start at cycle r0 (div = 0 there).
  task automatic push_run(input int c0, input int c1, input int r0, input bit fast,
                          input string tag);
    logic [4:0] v;
    int d;
    for (int c = c0; c <= c1; c++) begin
      d = (c - r0) % 8;
      v = '0;
      if (fast) begin
        v[3] = (d % 4 == 0);
        v[2] = (d % 4 == 2);
        v[1] = (d % 2 == 0);
      end else begin
        v[3] = (d == 0);
        v[2] = (d == 4);
        v[1] = (d % 4 == 0);
      end
      exp_q.push_back('{cyc: c, v: v, tag: tag});
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s cyc=%0d not sampled, required=%b", e.tag, e.cyc, e.v);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e   = exp_q.pop_front();
        act = {bus.core_reset, bus.ce, bus.ce_n, bus.ce_2x, bus.paused};
        n_cmp++;
        if (act !== e.v) begin
          n_bad++;
          $display("FAIL %s cyc=%0d {rst,ce,ce_n,ce_2x,paused} actual=%b required=%b",
                   e.tag, cyc, act, e.v);
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.fast_fwd   = 1'b0;
    bus.pause_req  = 1'b0;

    // Power-up: lock at cycle 10, release and first ce at cycle 29.
    push_vec(1, 28, VRst, "powerup_reset");
    push_run(29, 836, 29, 1'b0, "normal_rate");
    wait_until(2);
    rst_n = 1'b1;
    wait_until(10);
    bus.pll_locked = 1'b1;

    // Fast-forward requested at div = 3; takes effect from the next frame at 837.
    wait_until(832);
    bus.fast_fwd = 1'b1;
    push_run(837, 1644, 29, 1'b1, "fast_rate");

    // Back to normal, then pause requested at div = 2 of the frame starting at 1653.
    wait_until(1640);
    bus.fast_fwd = 1'b0;
    push_run(1645, 1660, 29, 1'b0, "pre_pause");
    push_vec(1661, 1680, VPause, "paused");
    wait_until(1655);
    bus.pause_req = 1'b1;
    wait_until(1670);
    bus.fast_fwd = 1'b1;

    // Resume: ce on the very next cycle, mode reloaded (fast) on exit.
    wait_until(1680);
    bus.pause_req = 1'b0;
    push_run(1681, 1728, 1681, 1'b1, "resume_fast");

    // Short pause pulse over div 1..3 and an in-frame fast_fwd glitch are both ignored.
    wait_until(1690);
    bus.pause_req = 1'b1;
    wait_until(1693);
    bus.pause_req = 1'b0;
    wait_until(1698);
    bus.fast_fwd = 1'b0;
    wait_until(1700);
    bus.fast_fwd = 1'b1;

    // Pause, then lose lock while paused with pause_req still high.
    wait_until(1721);
    bus.pause_req = 1'b1;
    push_vec(1729, 1736, VPause, "paused_2");
    push_vec(1737, 1768, VRst, "lockloss_paused");
    wait_until(1734);
    bus.pll_locked = 1'b0;
    wait_until(1745);
    bus.pause_req = 1'b0;

    // Relock: full hold sequence, fast mode loaded on release.
    wait_until(1750);
    bus.pll_locked = 1'b1;
    push_run(1769, 1802, 1769, 1'b1, "relock_fast");

    // Lose lock in RUN, relock in normal mode.
    wait_until(1800);
    bus.pll_locked = 1'b0;
    bus.fast_fwd   = 1'b0;
    push_vec(1803, 1828, VRst, "lockloss_run");
    wait_until(1810);
    bus.pll_locked = 1'b1;
    push_run(1829, 1860, 1829, 1'b0, "relock_normal");

    // Async reset pulse between edges; lock still high on release.
    wait_until(1860);
    push_vec(1861, 1879, VRst, "async_reset");
    push_run(1880, 1900, 1880, 1'b0, "after_reset");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
